// File: rtl/video_pkg.sv
// Shared definitions for the video read path.
//   CTI_*       Wishbone cycle-type identifiers used by the burst master
//   rd_state_t  control states of the frame reader
package video_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_BURST,
    ST_DONE
  } rd_state_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle, 32-bit data, with the clock and reset of the
// bus carried alongside the signals.
//   clk, rst   bus clock and synchronous active-high reset
//   adr        byte address
//   dat_ms     write data, master to slave
//   dat_sm     read data, slave to master
//   sel        byte lane selects
//   we         write enable
//   stb, cyc   strobe and cycle
//   cti, bte   cycle-type and burst-type identifiers
//   ack        slave acknowledge
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    input  clk, rst, dat_sm, ack,
    output adr, dat_ms, sel, we, stb, cyc, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is presented on dout
// whenever the FIFO is not empty; dout reads as zero while empty.
//   clk, rst  clock and synchronous active-high reset (empties the FIFO)
//   push, din write din when push is high
//   pop       drop the head word (ignored while empty)
//   dout      head word
//   empty     no words stored
//   full      DEPTH words stored
//   count     number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone burst master that reads one linear frame of FRAME_WORDS 32-bit
// words starting at BASE_ADR, in incrementing bursts of BURST_LEN beats,
// and hands the words to the pixel stage through a show-ahead FIFO.
//   wb_m        Wishbone master port (carries clk and synchronous rst)
//   start       begin one frame read; only honoured while idle
//   busy        a frame read is in progress
//   frame_done  one-cycle pulse once the last word of the frame is acked
//   pix_data    FIFO head word
//   pix_valid   FIFO not empty
//   pix_ready   consumer takes pix_data when pix_valid & pix_ready
module wb_frame_reader
  import video_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0,
  parameter int          FRAME_WORDS = 2048,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 32
) (
  wshb_if.master      wb_m,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int WCW = $clog2(FRAME_WORDS) + 1;
  localparam int BW  = $clog2(BURST_LEN);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  // Parameter legality
  if (BASE_ADR[1:0] != 2'b00) begin : g_bad_base
    $error("BASE_ADR must be 4-byte aligned");
  end
  if (BURST_LEN < 2 || (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_burst
    $error("BURST_LEN must be a power of two and at least 2");
  end
  if (FIFO_DEPTH < BURST_LEN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least BURST_LEN");
  end
  if (FRAME_WORDS < BURST_LEN || (FRAME_WORDS % BURST_LEN) != 0) begin : g_bad_frame
    $error("FRAME_WORDS must be a non-zero multiple of BURST_LEN");
  end

  rd_state_t       state;
  rd_state_t       state_nxt;
  logic [31:0]     adr;
  logic [WCW-1:0]  word_cnt;
  logic [BW-1:0]   beat_cnt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            beat_ack;
  logic            last_beat;
  logic            frame_last;
  logic            space_ok;

  assign beat_ack   = (state == ST_BURST) && wb_m.ack;
  assign last_beat  = (beat_cnt == BW'(BURST_LEN - 1));
  assign frame_last = (word_cnt == WCW'(FRAME_WORDS - 1));
  // Room for a whole burst must exist before it is issued; this is what
  // keeps the FIFO from ever overflowing regardless of ack timing.
  assign space_ok   = (fifo_count <= CW'(FIFO_DEPTH - BURST_LEN));

  // State register
  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (start)    state_nxt = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (space_ok) state_nxt = ST_BURST;
      ST_BURST: begin
        if (beat_ack && last_beat) begin
          state_nxt = frame_last ? ST_DONE : ST_WAIT_SPACE;
        end
      end
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; leaving BURST drops cyc/stb right after the
  // last ack and every burst is separated by at least one WAIT_SPACE cycle.
  always_comb begin
    wb_m.cyc   = 1'b0;
    wb_m.stb   = 1'b0;
    wb_m.cti   = CTI_CLASSIC;
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
    if (state == ST_BURST) begin
      wb_m.cyc = 1'b1;
      wb_m.stb = 1'b1;
      wb_m.cti = last_beat ? CTI_END : CTI_INCR;
    end
  end

  // Address, beat and word counters. The beat counter is exactly log2 of a
  // power-of-two burst length, so it wraps to zero at the end of each burst.
  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      adr      <= BASE_ADR;
      word_cnt <= '0;
      beat_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      adr      <= BASE_ADR;
      word_cnt <= '0;
      beat_cnt <= '0;
    end else if (beat_ack) begin
      adr      <= adr + 32'd4;
      word_cnt <= word_cnt + 1'b1;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign wb_m.adr    = adr;
  assign wb_m.dat_ms = 32'h0;
  assign wb_m.sel    = 4'hF;
  assign wb_m.we     = 1'b0;
  assign wb_m.bte    = 2'b00;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_m.clk),
    .rst   (wb_m.rst),
    .push  (beat_ack),
    .pop   (pix_ready),
    .din   (wb_m.dat_sm),
    .dout  (pix_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign pix_valid = ~fifo_empty;

  // The space check makes this unreachable; firing means the control is broken.
  always_ff @(posedge wb_m.clk) begin
    if (!wb_m.rst) begin
      assert (!(beat_ack && fifo_full));
    end
  end

endmodule

// File: tb/tb_wb_frame_reader.sv
module tb_wb_frame_reader;
  import video_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int FW    = 64;
  localparam int BL    = 16;
  localparam int DEPTH = 32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  wshb_if wb (.clk(clk), .rst(rst));

  wb_frame_reader #(
    .BASE_ADR    (BASE),
    .FRAME_WORDS (FW),
    .BURST_LEN   (BL),
    .FIFO_DEPTH  (DEPTH)
  ) u_dut (
    .wb_m       (wb),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment state shared between the directed sequence and the bus model
  logic [31:0] mem [FW];
  logic [31:0] q [$];
  int ack_mode   = 0;  // 0 every cycle, 1 every 3rd stb cycle, 2 random
  int rdy_mode   = 0;  // 0 always, 1 never, 2 random, 3 budgeted, 4 pop only on push at 31
  int pop_budget = 0;
  int simul_budget = 0;
  int simul_hits = 0;
  int slow_cnt   = 0;
  int nbeats     = 0;
  int bursts     = 0;
  int popped     = 0;
  int done_cnt   = 0;
  logic cyc_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wishbone slave, consumer and reference model, all evaluated mid-cycle.
  always @(negedge clk) begin
    logic ack_now;
    if (rst) begin
      q.delete();
      nbeats     = 0;
      wb.ack     = 1'b0;
      wb.dat_sm  = 32'h0;
      pix_ready  = 1'b0;
      cyc_prev   = 1'b0;
    end else begin
      ack_now = 1'b0;
      if (wb.cyc && wb.stb) begin
        case (ack_mode)
          0: ack_now = 1'b1;
          1: begin slow_cnt++; ack_now = (slow_cnt % 3 == 0); end
          default: ack_now = ($urandom_range(0, 1) == 1);
        endcase
      end
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'b0;
        2: pix_ready = ($urandom_range(0, 1) == 1);
        3: pix_ready = (pop_budget > 0);
        default: pix_ready = (q.size() == DEPTH - 1) && ack_now && (simul_budget > 0);
      endcase
      chk("pix_valid", pix_valid, q.size() != 0);
      chk("fifo_count", 32'(u_dut.fifo_count), q.size());
      if (q.size() != 0 && pix_ready) begin
        chk("pix_data", pix_data, q[0]);
        void'(q.pop_front());
        popped++;
        if (rdy_mode == 3) pop_budget--;
        if (rdy_mode == 4) begin simul_budget--; simul_hits++; end
      end
      if (ack_now) begin
        chk("adr", wb.adr, BASE + 32'(nbeats * 4));
        chk("cti", wb.cti, ((nbeats % BL) == BL - 1) ? CTI_END : CTI_INCR);
        chk("beat_in_frame", nbeats < FW, 1);
        wb.dat_sm = mem[nbeats % FW];
        q.push_back(mem[nbeats % FW]);
        nbeats++;
      end else begin
        wb.dat_sm = $urandom;
      end
      wb.ack = ack_now;
      if (wb.cyc && !cyc_prev) bursts++;
      cyc_prev = wb.cyc;
      if (frame_done) begin
        chk("frame_len", nbeats, FW);
        done_cnt++;
        nbeats = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    bursts = 0; popped = 0; done_cnt = 0; slow_cnt = 0; simul_hits = 0;
  endtask

  task automatic fill_mem(input bit nominal);
    for (int i = 0; i < FW; i++) mem[i] = nominal ? 32'hA500_0000 + 32'(i) : $urandom;
  endtask

  task automatic start_frame(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_cyc_before_space"}, wb.cyc, 0);
    step();
    chk({tag, "_cyc_after_space"}, wb.cyc, 1);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done_cnt < 1 && n < bound) begin step(); n++; end
    chk({tag, "_done_in_time"}, done_cnt >= 1, 1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (popped < FW && n < bound) begin step(); n++; end
    chk({tag, "_words_out"}, popped, FW);
  endtask

  initial begin
    int n;
    bit got;
    rst = 1'b1;
    start = 1'b0;
    fill_mem(1'b1);
    repeat (3) step();
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_cti", wb.cti, CTI_CLASSIC);
    chk("rst_adr", wb.adr, BASE);
    chk("rst_pix_data", pix_data, 0);
    chk("const_we", wb.we, 0);
    chk("const_sel", wb.sel, 4'hF);
    chk("const_dat_ms", wb.dat_ms, 0);
    chk("const_bte", wb.bte, 2'b00);
    rst = 1'b0;
    step();

    // Nominal frame, no backpressure
    clear_counts(); ack_mode = 0; rdy_mode = 0;
    start_frame("nom");
    wait_done("nom", 400);
    wait_drain("nom", 100);
    repeat (4) step();
    chk("nom_bursts", bursts, 4);
    chk("nom_done_pulses", done_cnt, 1);
    chk("nom_idle_busy", busy, 0);

    // Backpressure: FIFO fills with two bursts, then waits for space
    fill_mem(1'b0);
    clear_counts(); ack_mode = 0; rdy_mode = 1;
    start_frame("bp");
    repeat (100) step();
    chk("bp_bursts_full", bursts, 2);
    chk("bp_cyc_waiting", wb.cyc, 0);
    chk("bp_busy", busy, 1);
    chk("bp_count_full", 32'(u_dut.fifo_count), DEPTH);
    pop_budget = 16; rdy_mode = 3;
    n = 0;
    while (pop_budget > 0 && n < 60) begin step(); n++; end
    chk("bp_pops_done", pop_budget, 0);
    simul_budget = 1; rdy_mode = 4;
    got = 1'b0;
    for (int k = 0; k < 3 && !got; k++) begin
      if (wb.cyc) got = 1'b1;
      else step();
    end
    chk("bp_resume_within_2", got, 1);
    n = 0;
    while (simul_hits < 1 && n < 100) begin step(); n++; end
    chk("bp_push_pop_at_31", simul_hits, 1);
    step();
    chk("bp_count_stays_31", 32'(u_dut.fifo_count), DEPTH - 1);
    rdy_mode = 0;
    wait_done("bp", 400);
    wait_drain("bp", 100);
    chk("bp_bursts_total", bursts, 4);

    // Slow slave, ack every third stb cycle, random consumer
    fill_mem(1'b1);
    clear_counts(); ack_mode = 1; rdy_mode = 2;
    start_frame("slow");
    wait_done("slow", 800);
    rdy_mode = 0;
    wait_drain("slow", 100);
    chk("slow_bursts", bursts, 4);

    // start pulses during BURST and DONE are ignored
    fill_mem(1'b0);
    clear_counts(); ack_mode = 2; rdy_mode = 2;
    start_frame("ign");
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!frame_done && n < 1000) begin step(); n++; end
    chk("ign_done_seen", frame_done, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_idle_after_done", busy, 0);
    repeat (6) step();
    chk("ign_still_idle", busy, 0);
    chk("ign_no_cyc", wb.cyc, 0);
    rdy_mode = 0;
    wait_drain("ign", 100);
    chk("ign_one_frame", done_cnt, 1);
    chk("ign_bursts", bursts, 4);

    // Reset on beat 7 of burst 2, then a clean frame from word 0
    fill_mem(1'b0);
    clear_counts(); ack_mode = 0; rdy_mode = 0;
    start_frame("rst");
    n = 0;
    while (nbeats < BL + 6 && n < 100) begin step(); n++; end
    chk("rst_reached_beat", nbeats, BL + 6);
    rst = 1'b1;
    step();
    chk("rst_mid_cyc", wb.cyc, 0);
    chk("rst_mid_stb", wb.stb, 0);
    chk("rst_mid_valid", pix_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_adr", wb.adr, BASE);
    chk("rst_mid_cti", wb.cti, CTI_CLASSIC);
    chk("rst_mid_pix_data", pix_data, 0);
    rst = 1'b0;
    step();
    repeat (3) step();
    chk("rst_no_resume", wb.cyc, 0);
    clear_counts();
    start_frame("rerun");
    wait_done("rerun", 400);
    wait_drain("rerun", 100);
    chk("rerun_bursts", bursts, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
